// File: rtl/vblank_scheduler.sv
// vblank_scheduler: shares the vertical-blanking interval between N_REQ update
// agents. One update window opens per frame; agents are granted one at a time in
// round-robin order, at most once per frame, each grant bounded by MAX_SLOT cycles.
module vblank_scheduler #(
  parameter int N_REQ       = 4,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 521,
  parameter int GUARD_LINES = 1,
  parameter int MAX_SLOT    = 2048,
  localparam int ID_W       = $clog2(N_REQ),
  localparam int CNT_W      = $clog2(MAX_SLOT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       y,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             window,
  output logic             abort,
  output logic [N_REQ-1:0] miss
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_HOLD} state_t;

  localparam logic [9:0]       Y_OPEN   = 10'(V_ACTIVE);
  localparam logic [9:0]       Y_CLOSE  = 10'(V_TOTAL - GUARD_LINES);
  localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(MAX_SLOT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               window_q, window_d;
  logic               win_prev_q, win_prev_d;
  logic               win_vld_q, win_vld_d;
  logic               prev_vld_q, prev_vld_d;
  logic               abort_q, abort_d;
  logic [N_REQ-1:0]   miss_q, miss_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   served_q, served_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;

  logic               win_rise, win_fall;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    next_ptr;

  // Round-robin search: first eligible index at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                            input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    int              j;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = ID_W'(j);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Window edges only count once the history holds two real samples, so a reset
  // released in mid-blanking does not look like a window opening.
  assign win_rise = prev_vld_q && window_q && !win_prev_q;
  assign win_fall = prev_vld_q && !window_q && win_prev_q;

  assign {pick_found, pick_id} = rr_pick(req & ~served_q, rr_ptr_q);
  assign next_ptr = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

  // Next-state and registered-output logic for the window tracker and arbiter FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    served_d   = served_q;
    slot_cnt_d = slot_cnt_q;
    abort_d    = 1'b0;
    miss_d     = '0;
    window_d   = (y >= Y_OPEN) && (y < Y_CLOSE);
    win_prev_d = window_q;
    win_vld_d  = 1'b1;
    prev_vld_d = win_vld_q;

    // Report unserved requests from the frame's served set before this cycle's update.
    if (win_fall) miss_d = req & ~served_q;

    case (state_q)
      S_IDLE: begin
        if (win_rise) begin
          served_d = '0;
          state_d  = S_ARB;
        end
      end
      S_ARB: begin
        if (!window_q) begin
          state_d = S_IDLE;
        end else if (pick_found) begin
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          slot_cnt_d     = '0;
          state_d        = S_GRANT;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_GRANT: begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (done[gnt_id_q]) begin
          gnt_d              = '0;
          served_d[gnt_id_q] = 1'b1;
          rr_ptr_d           = next_ptr;
          state_d            = S_ARB;
        end else if (!window_q) begin
          abort_d            = 1'b1;
          gnt_d              = '0;
          served_d[gnt_id_q] = 1'b1;
          rr_ptr_d           = next_ptr;
          state_d            = S_IDLE;
        end else if (slot_cnt_q == SLOT_END) begin
          abort_d            = 1'b1;
          gnt_d              = '0;
          served_d[gnt_id_q] = 1'b1;
          rr_ptr_d           = next_ptr;
          state_d            = S_ARB;
        end
      end
      S_HOLD: begin
        if (!window_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; asynchronous reset returns every flop to its idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      window_q   <= 1'b0;
      win_prev_q <= 1'b0;
      win_vld_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      abort_q    <= 1'b0;
      miss_q     <= '0;
      rr_ptr_q   <= '0;
      served_q   <= '0;
      slot_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      window_q   <= window_d;
      win_prev_q <= win_prev_d;
      win_vld_q  <= win_vld_d;
      prev_vld_q <= prev_vld_d;
      abort_q    <= abort_d;
      miss_q     <= miss_d;
      rr_ptr_q   <= rr_ptr_d;
      served_q   <= served_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign window = window_q;
  assign abort  = abort_q;
  assign miss   = miss_q;

endmodule
